// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// A radix-2 shift-add multiplier and a restoring divider share one 64-bit
// accumulator and use one bit per cycle. Division by zero and signed
// overflow finish without iterating.
//
// Optional build macro: MULDIV_FAST_MUL_EN. When it is defined, multiplies
// use a single-cycle combinational product and go straight to DONE.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid / in_ready  request handshake (op, a, b sampled on accept)
//   op                   funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a, b                 rs1 / rs2 operands
//   flush                kills the in-flight op, blocks accept while high
//   out_valid/out_ready  result handshake
//   result               32-bit result, held in DONE until transfer
//   busy                 state is not IDLE
//
// state | meaning
// IDLE  | waiting for a request
// CALC  | one multiply/divide bit per cycle, 32 cycles
// DONE  | result valid, waiting for out_ready
module riscv_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     mcand_q, mcand_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                is_div, sgn_a, sgn_b, b_zero, div_ovf, special;
    logic [XLEN-1:0]     a_mag, b_mag, special_res;
    logic [XLEN:0]       mul_sum, div_shl, div_trial;
    logic [2*XLEN-1:0]   step, step_neg;
    logic [XLEN-1:0]     div_val, final_res;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0]   fast_prod;
    logic [XLEN-1:0]     fast_res;
`endif

    // Operand decode for a new request.
    always_comb begin
        is_div = op[2];
        sgn_a  = a[XLEN-1] & (is_div ? ~op[0] : (op == 3'b001 || op == 3'b010));
        sgn_b  = b[XLEN-1] & (is_div ? ~op[0] : (op == 3'b001));
        a_mag  = sgn_a ? -a : a;
        b_mag  = sgn_b ? -b : b;
        b_zero  = (b == '0);
        div_ovf = is_div & ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
        special = is_div & (b_zero | div_ovf);
        if (b_zero) special_res = op[1] ? a : '1;
        else        special_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

`ifdef MULDIV_FAST_MUL_EN
    // 33-bit sign-extended operands; the product is taken modulo 2^64.
    always_comb begin
        fast_prod = $signed({sgn_a, a}) * $signed({sgn_b, b});
        fast_res  = (op[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    // One iteration step. acc holds {product_hi, multiplier} for multiply
    // and {remainder, dividend/quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        div_shl   = acc_q[2*XLEN-1:XLEN-1];
        div_trial = div_shl - {1'b0, mcand_q};
        if (!op_q[2])             step = {mul_sum, acc_q[XLEN-1:1]};
        else if (!div_trial[XLEN]) step = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else                      step = {div_shl[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

        step_neg  = neg_q ? -step : step;
        div_val   = op_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
        if (!op_q[2])
            final_res = (op_q[1:0] == 2'b00) ? step_neg[XLEN-1:0] : step_neg[2*XLEN-1:XLEN];
        else
            final_res = neg_q ? -div_val : div_val;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    op_d  = op;
                    cnt_d = '0;
                    // Remainder follows the dividend sign; everything else follows sign xor.
                    neg_d = (is_div && op[1]) ? sgn_a : (sgn_a ^ sgn_b);
                    if (special) begin
                        result_d = special_res;
                        state_d  = DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!is_div) begin
                        result_d = fast_res;
                        state_d  = DONE;
                    end
`endif
                    else begin
                        acc_d   = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                        mcand_d = is_div ? b_mag : a_mag;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        result_d = final_res;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (flush || out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !flush;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
module tb_riscv_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op_i = 3'b000;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int tests = 0;
    int fails = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010,
                           OP_MULHU = 3'b011, OP_DIV = 3'b100, OP_DIVU = 3'b101,
                           OP_REM = 3'b110, OP_REMU = 3'b111;

    riscv_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op_i),
        .a         (a_i),
        .b         (b_i),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op, measure edges from accept (accept edge = 1) to out_valid,
    // optionally hold off out_ready for some cycles, then retire the result.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int lat,
                          input int hold);
        int n;
        @(negedge clk);
        op_i = o; a_i = x; b_i = y; in_valid = 1'b1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(lat));
        check({tag, "_result"}, 64'(result), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_result"}, 64'(result), 64'(exp));
            check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_idle_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int bad;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        run_op("mul_7x6",     OP_MUL,    32'd7,          32'd6,          32'h0000_002A, MUL_LAT, 0);
        run_op("mulh_m1m1",   OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, MUL_LAT, 0);
        run_op("mulhu_m1m1",  OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, MUL_LAT, 0);
        run_op("mulhsu_m1x2", OP_MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF, MUL_LAT, 0);
        run_op("div_m20_3",   OP_DIV,    32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFA, DIV_LAT, 0);
        run_op("rem_m20_3",   OP_REM,    32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFE, DIV_LAT, 0);
        run_op("div_20_m3",   OP_DIV,    32'd20,         32'hFFFF_FFFD,  32'hFFFF_FFFA, DIV_LAT, 0);
        run_op("rem_20_m3",   OP_REM,    32'd20,         32'hFFFF_FFFD,  32'h0000_0002, DIV_LAT, 0);
        run_op("divu_100_7",  OP_DIVU,   32'd100,        32'd7,          32'd14,        DIV_LAT, 0);
        run_op("remu_100_7",  OP_REMU,   32'd100,        32'd7,          32'd2,         DIV_LAT, 0);
        run_op("divu_5_0",    OP_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF, 1, 0);
        run_op("remu_5_0",    OP_REMU,   32'd5,          32'd0,          32'd5,         1, 0);
        run_op("div_ovf",     OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1, 0);
        run_op("rem_ovf",     OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 1, 0);
        run_op("backpress",   OP_DIVU,   32'd100,        32'd7,          32'd14,        DIV_LAT, 5);

        // Flush in IDLE blocks acceptance.
        @(negedge clk);
        op_i = OP_MUL; a_i = 32'd3; b_i = 32'd5; in_valid = 1'b1; flush = 1'b1;
        #1;
        check("flush_idle_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        check("flush_idle_busy", 64'(busy), 64'd0);

        // Flush at CALC cycle 10.
        @(negedge clk);
        flush = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("flush_calc_busy", 64'(busy), 64'd1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_calc_idle", 64'(busy), 64'd0);
        check("flush_calc_valid", 64'(out_valid), 64'd0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) bad++;
        end
        check("flush_never_valid", 64'(bad), 64'd0);

        // Async reset in the middle of CALC.
        @(negedge clk);
        op_i = OP_MUL; a_i = 32'd3; b_i = 32'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("mul_3x4", OP_MUL, 32'd3, 32'd4, 32'd12, MUL_LAT, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
